downsample_filter_121: RTL and testbench
========================================

// Module: downsample_filter_121
// PURPOSE
//  Downstream stage of the 3-tap pixel shift chain. Takes the three taps (newest..oldest), applies a
//  1-2-1 horizontal kernel, decimates by 2 and hands each reduced pixel to the write-back stage over a
//  valid/ready handshake. Tracks column position per row, suppresses partial windows and drains at row end.
// PARAMETERS
//  PIX_W    8    pixel width, bits
//  ROW_LEN  256  input pixels per row; even, >= 4
// PORTS
//  clk        in   1        single clock, rising edge
//  reset      in   1        synchronous, active-high
//  in_valid   in   1        new pixel shifted into chain; taps valid this cycle
//  in_ready   out  1        stage accepts; upstream shifts only on in_valid & in_ready
//  tap0       in   PIX_W    newest pixel (first chain register)
//  tap1       in   PIX_W    middle pixel
//  tap2       in   PIX_W    oldest pixel (third chain register)
//  out_valid  out  1        out_pix valid
//  out_ready  in   1        consumer accepts
//  out_pix    out  PIX_W    filtered, decimated pixel
//  out_last   out  1        qualifies out_valid: last output of row
//  row_done   out  1        1-cycle pulse after row fully drained
// BEHAVIOUR
//  - Reset: in_ready=0 in reset cycle then 1; out_valid=0, out_pix=0, out_last=0, row_done=0,
//    col=0, state=FILL, pipeline empty. Reset mid-row discards in-flight data; no partial output.
//  - Accept = in_valid & in_ready; col increments per accept (0..ROW_LEN-1).
//  - FSM: FILL (col<2, accepts update col only) -> RUN when col reaches 2.
//    RUN: accept at even col>=2 is an emit; odd cols counted only. Accept at col=ROW_LEN-1 -> DRAIN.
//    DRAIN: in_ready=0 until s1 and output register empty; then row_done=1 one cycle, col=0 -> FILL.
//  - Outputs per row = (ROW_LEN-2)/2 (127 at default); out_last set on emit at col=ROW_LEN-2.
//  - Arithmetic: sum = tap2 + 2*tap1 + tap0, width PIX_W+2, no overflow; out = sum>>2 (see CONFIG).
//    Result always <= 2^PIX_W-1, no saturation needed.
//  - Pipeline: s1 registers sum+last on emit; s2 is out register. Latency: emit accept at cycle N ->
//    out_valid at N+2 when out_ready held high. Throughput 1 emit/cycle.
//  - Handshake: s2 loads when !out_valid | out_ready; s1 advances when s2 loads;
//    in_ready = state!=DRAIN & (!s1_valid | s2 loads). out_pix/out_last stable while out_valid & !out_ready.
//    out_valid never drops without out_ready. Non-emit accepts follow same in_ready rule.
//  - Simultaneous emit accept + output drain in one cycle: both occur, no bubble.
// CONFIGURATION
//  DS_ROUND_EN defined: out = (sum+2)>>2 (round half up; sum+2 computed in PIX_W+2 bits, max 1022 fits).
//  DS_ROUND_EN undefined: out = sum>>2 (truncate). No other behaviour differs.
// STRUCTURE
//  Package ds_pkg: PIX_W default, SUM_W = PIX_W+2 constant, state typedef {FILL,RUN,DRAIN},
//  col counter width function clog2(ROW_LEN).
//  Sub-module ds_kernel_121: combinational tap0/1/2 -> scaled pixel incl. DS_ROUND_EN choice.
//  Top holds FSM, col counter, s1/s2 registers, handshake logic.
// TESTING
//  1 Constant row of 100, out_ready=1 -> 127 outputs all 100; out_last on 127th only; row_done 1 cycle
//    after it; in_ready low during DRAIN.
//  2 Taps (tap2,tap1,tap0)=(1,2,2), sum=7 -> out_pix=1 without DS_ROUND_EN, 2 with it.
//  3 All taps 255 -> out_pix=255 both builds; ramp 0..255 -> out_pix=col-1 at each even col (exact).
//  4 out_ready low 5 cycles mid-row -> out_pix/out_last stable, in_ready falls when s1 full,
//    no output lost or duplicated; order preserved after release.
//  5 reset at col 100 with out_valid=1 -> next cycle out_valid=0, col=0; first new output only after
//    3 accepts, 2 cycles after third accept.
//  6 in_valid held high across row boundary -> no accept during DRAIN; first pixel of next row accepted
//    cycle after row_done; second row yields identical 127-output count.

Source files
------------

// File: rtl/ds_pkg.sv
// Shared constants, state encoding and sizing helper for the 1-2-1 decimating filter.
package ds_pkg;

    localparam int unsigned DS_PIX_W   = 8;
    localparam int unsigned DS_ROW_LEN = 256;
    localparam int unsigned SUM_W      = DS_PIX_W + 2;

    typedef enum logic [1:0] {
        FILL,
        RUN,
        DRAIN
    } ds_state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r = 0;
        while ((32'd1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/ds_kernel_121.sv
// Combinational 1-2-1 horizontal kernel, scaled by 1/4.
// DS_ROUND_EN selects round-half-up instead of truncation.
module ds_kernel_121
    import ds_pkg::*;
#(
    parameter int unsigned PIX_W = DS_PIX_W
) (
    input  logic [PIX_W-1:0] tap0,
    input  logic [PIX_W-1:0] tap1,
    input  logic [PIX_W-1:0] tap2,
    output logic [PIX_W-1:0] pix
);

    localparam int unsigned KSUM_W = PIX_W + 2;

    logic [KSUM_W-1:0] sum;
    logic [KSUM_W-1:0] scaled;

    // Max sum is 4*(2^PIX_W-1); +2 still fits in PIX_W+2 bits.
    always_comb begin
        sum = KSUM_W'(tap2) + {1'b0, tap1, 1'b0} + KSUM_W'(tap0);
`ifdef DS_ROUND_EN
        scaled = sum + KSUM_W'(2);
`else
        scaled = sum;
`endif
        pix = PIX_W'(scaled >> 2);
    end

endmodule

// File: rtl/downsample_filter_121.sv
// 1-2-1 filter with 2:1 decimation, per-row column tracking and end-of-row drain.
// Optional rounding via DS_ROUND_EN (see ds_kernel_121).
module downsample_filter_121
    import ds_pkg::*;
#(
    parameter int unsigned PIX_W   = DS_PIX_W,
    parameter int unsigned ROW_LEN = DS_ROW_LEN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] tap0,
    input  logic [PIX_W-1:0] tap1,
    input  logic [PIX_W-1:0] tap2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_pix,
    output logic             out_last,
    output logic             row_done
);

    localparam int unsigned      COL_W     = clog2(ROW_LEN);
    localparam logic [COL_W-1:0] COL_ONE   = COL_W'(1);
    localparam logic [COL_W-1:0] COL_LASTE = COL_W'(ROW_LEN - 2);
    localparam logic [COL_W-1:0] COL_END   = COL_W'(ROW_LEN - 1);

    ds_state_t        state, state_nxt;
    logic [COL_W-1:0] col;
    logic             accept, emit, s2_load, drained;
    logic             s1_valid, s1_last;
    logic [PIX_W-1:0] s1_pix, k_pix;

    ds_kernel_121 #(.PIX_W(PIX_W)) u_kernel (
        .tap0 (tap0),
        .tap1 (tap1),
        .tap2 (tap2),
        .pix  (k_pix)
    );

    assign accept  = in_valid & in_ready;
    assign emit    = accept & (state == RUN) & ~col[0];
    assign s2_load = ~out_valid | out_ready;
    assign drained = ~s1_valid & ~out_valid;

    always_ff @(posedge clk) begin
        if (reset) state <= FILL;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (accept && col == COL_ONE) state_nxt = RUN;
            RUN:     if (accept && col == COL_END) state_nxt = DRAIN;
            DRAIN:   if (drained)                  state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    always_comb begin
        in_ready = ~reset & (state != DRAIN) & (~s1_valid | s2_load);
        row_done = ~reset & (state == DRAIN) & drained;
    end

    always_ff @(posedge clk) begin
        if (reset)       col <= '0;
        else if (accept) col <= (col == COL_END) ? '0 : col + COL_ONE;
    end

    // s1 refills on an emit even while s2 drains it in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_pix   <= '0;
            s1_last  <= 1'b0;
        end else if (emit) begin
            s1_valid <= 1'b1;
            s1_pix   <= k_pix;
            s1_last  <= (col == COL_LASTE);
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_pix   <= '0;
            out_last  <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            out_pix   <= s1_pix;
            out_last  <= s1_valid & s1_last;
        end
    end

endmodule

// File: tb/tb_downsample_filter_121.sv
// Self-checking bench for downsample_filter_121: table vectors plus scoreboard queue.
module tb_downsample_filter_121;

    localparam int ROW = 256;
    localparam int NOUT = (ROW - 2) / 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] tap0 = '0, tap1 = '0, tap2 = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_pix;
    logic       out_last;
    logic       row_done;

    downsample_filter_121 #(.PIX_W(8), .ROW_LEN(ROW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .tap0      (tap0),
        .tap1      (tap1),
        .tap2      (tap2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pix   (out_pix),
        .out_last  (out_last),
        .row_done  (row_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] pix;
        logic       last;
    } exp_t;

    typedef struct {
        logic [7:0] t2, t1, t0, et, er;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl[13];

    int n_checks = 0, n_fail = 0;
    int cyc = 0;
    int bcol = 0;
    int row_outs = 0, rows_done = 0;
    int last_cyc = -100, last_rd_cyc = -100;
    bit drain_flag = 0, rd_prev = 0, stall_prev = 0, blocked_seen = 0;
    logic [7:0] held_pix;
    logic       held_last;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] model(input logic [7:0] a2, a1, a0);
        int s = int'(a2) + 2 * int'(a1) + int'(a0);
`ifdef DS_ROUND_EN
        s += 2;
`endif
        return 8'(s / 4);
    endfunction

    // Output monitor: scoreboard pops, stall stability, drain and row_done checks.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            stall_prev = 0;
            rd_prev    = 0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_pix", out_pix, held_pix);
                chk("stall_last", out_last, held_last);
            end
            if (drain_flag) chk("drain_in_ready", in_ready, 0);
            if (rd_prev) chk("ready_after_row_done", in_ready, 1);
            if (!out_ready && in_valid && !in_ready && !drain_flag) blocked_seen = 1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_pix", out_pix, e.pix);
                    chk("out_last", out_last, e.last);
                    row_outs++;
                    if (e.last) begin
                        chk("row_out_count", row_outs, NOUT);
                        row_outs = 0;
                        last_cyc = cyc;
                    end
                end
            end
            if (row_done) begin
                chk("row_done_timing", cyc, last_cyc + 1);
                rows_done++;
                drain_flag  = 0;
                last_rd_cyc = cyc;
            end
            rd_prev    = row_done;
            stall_prev = out_valid && !out_ready;
            held_pix   = out_pix;
            held_last  = out_last;
        end
    end

    task automatic accept_pix(input logic [7:0] a2, a1, a0, input logic [7:0] e, output int acc_cyc);
        exp_t ex;
        bit ok = 0;
        tap2 = a2; tap1 = a1; tap0 = a0; in_valid = 1'b1;
        for (int w = 0; w < 2000; w++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        acc_cyc = cyc;
        if (!ok) begin
            chk("in_ready_timeout", 0, 1);
        end else if (bcol >= 2 && bcol % 2 == 0) begin
            ex.pix  = e;
            ex.last = (bcol == ROW - 2);
            exp_q.push_back(ex);
        end
        @(posedge clk); #1;
        if (ok) begin
            if (bcol == ROW - 1) begin
                bcol = 0;
                drain_flag = 1;
            end else begin
                bcol++;
            end
        end
    endtask

    task automatic row_random(input int from_col, input int stall_col);
        logic [7:0] a2, a1, a0;
        int acc;
        for (int c = from_col; c < ROW; c++) begin
            if (c == stall_col) begin
                fork
                    begin
                        out_ready = 1'b0;
                        repeat (5) @(posedge clk);
                        #1 out_ready = 1'b1;
                    end
                join_none
            end
            a2 = 8'($urandom_range(0, 255));
            a1 = 8'($urandom_range(0, 255));
            a0 = 8'($urandom_range(0, 255));
            accept_pix(a2, a1, a0, model(a2, a1, a0), acc);
        end
    endtask

    initial begin
        int acc, acc3, k;
        logic [7:0] e;
        vec_t v;

        tbl[0]  = '{8'd1,   8'd2,   8'd2,   8'd1,   8'd2};
        tbl[1]  = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
        tbl[2]  = '{8'd0,   8'd0,   8'd0,   8'd0,   8'd0};
        tbl[3]  = '{8'd100, 8'd100, 8'd100, 8'd100, 8'd100};
        tbl[4]  = '{8'd0,   8'd0,   8'd1,   8'd0,   8'd0};
        tbl[5]  = '{8'd0,   8'd1,   8'd0,   8'd0,   8'd1};
        tbl[6]  = '{8'd3,   8'd0,   8'd0,   8'd0,   8'd1};
        tbl[7]  = '{8'd10,  8'd20,  8'd30,  8'd20,  8'd20};
        tbl[8]  = '{8'd255, 8'd0,   8'd255, 8'd127, 8'd128};
        tbl[9]  = '{8'd1,   8'd1,   8'd1,   8'd1,   8'd1};
        tbl[10] = '{8'd0,   8'd255, 8'd0,   8'd127, 8'd128};
        tbl[11] = '{8'd200, 8'd100, 8'd50,  8'd112, 8'd113};
        tbl[12] = '{8'd254, 8'd255, 8'd255, 8'd254, 8'd255};

        // Reset state
        @(negedge clk);
        chk("reset_in_ready", in_ready, 0);
        @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_pix", out_pix, 0);
        chk("reset_out_last", out_last, 0);
        chk("reset_row_done", row_done, 0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("post_reset_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Constant row of 100
        for (int c = 0; c < ROW; c++) accept_pix(8'd100, 8'd100, 8'd100, 8'd100, acc);

        // Table-driven kernel vectors on the emit columns
        k = 0;
        for (int c = 0; c < ROW; c++) begin
            if (c >= 2 && c % 2 == 0) begin
                v = tbl[k % 13];
                k++;
`ifdef DS_ROUND_EN
                e = v.er;
`else
                e = v.et;
`endif
                accept_pix(v.t2, v.t1, v.t0, e, acc);
            end else begin
                accept_pix(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                           8'($urandom_range(0, 255)), 8'd0, acc);
            end
        end

        // Ramp 0..255 through a real shift chain: output equals col-1
        for (int c = 0; c < ROW; c++) begin
            accept_pix((c >= 2) ? 8'(c - 2) : 8'd0, (c >= 1) ? 8'(c - 1) : 8'd0,
                       8'(c), 8'(c - 1), acc);
        end

        // Downstream stall mid-row
        blocked_seen = 0;
        row_random(0, 60);
        chk("stall_blocked_in_ready", blocked_seen, 1);

        // Reset mid-row with an output pending
        for (int c = 0; c <= 100; c++) begin
            accept_pix(8'(c), 8'(c + 1), 8'(c + 2), model(8'(c), 8'(c + 1), 8'(c + 2)), acc);
        end
        in_valid = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ov_before_reset", out_valid, 1);
        #1 reset = 1'b1;
        exp_q.delete();
        bcol = 0;
        row_outs = 0;
        drain_flag = 0;
        #1 chk("reset_mid_in_ready", in_ready, 0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_mid_out_valid", out_valid, 0);
        chk("reset_mid_out_last", out_last, 0);
        chk("reset_mid_row_done", row_done, 0);
        chk("reset_mid_in_ready_after", in_ready, 1);
        @(posedge clk); #1;
        accept_pix(8'd7, 8'd7, 8'd7, 8'd0, acc);
        accept_pix(8'd9, 8'd9, 8'd9, 8'd0, acc);
        accept_pix(8'd40, 8'd80, 8'd120, model(8'd40, 8'd80, 8'd120), acc3);
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_cycle", cyc, acc3 + 1);
        chk("lat_no_early", out_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("lat_first_out", out_valid, 1);
        @(posedge clk); #1;
        row_random(3, -1);

        // Back-to-back rows with in_valid held across the boundary
        row_random(0, -1);
        accept_pix(8'd5, 8'd6, 8'd7, 8'd0, acc);
        chk("accept_after_row_done", acc, last_rd_cyc + 1);
        row_random(1, -1);

        in_valid = 1'b0;
        for (int w = 0; w < 1000; w++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && rows_done >= 7 && !out_valid) break;
        end
        chk("queue_empty", exp_q.size(), 0);
        chk("rows_done", rows_done, 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
